mem_xbar: RTL and testbench



---
 rtl/mem_xbar_pkg.sv | 42 ++++
 rtl/mem_xbar_rr_arbiter.sv | 34 +++
 rtl/mem_xbar.sv | 170 +++++++++++++++++
 tb/tb_mem_xbar.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_xbar_pkg.sv
// rtl/mem_xbar_pkg.sv - shared slave indices, default address map and state type for mem_xbar
package mem_xbar_pkg;

  // Slave port assignment used by the SoC top
  localparam int SLV_ROM   = 0;
  localparam int SLV_UART  = 1;
  localparam int SLV_CLINT = 2;
  localparam int SLV_AVL   = 3;
  localparam int N_SLV_DEF = 4;

  // Base (inclusive) and top (exclusive) of each peripheral window
  localparam logic [31:0] ROM_BASE   = 32'h0000_0000;
  localparam logic [31:0] ROM_TOP    = 32'h0001_0000;
  localparam logic [31:0] UART_BASE  = 32'h1000_0000;
  localparam logic [31:0] UART_TOP   = 32'h1000_1000;
  localparam logic [31:0] CLINT_BASE = 32'h0200_0000;
  localparam logic [31:0] CLINT_TOP  = 32'h0201_0000;
  localparam logic [31:0] AVL_BASE   = 32'h8000_0000;
  localparam logic [31:0] AVL_TOP    = 32'h9000_0000;

  // Default map; element k of each array belongs to slave port k
  localparam logic [N_SLV_DEF-1:0][31:0] DEF_SLV_BASE = {AVL_BASE, CLINT_BASE, UART_BASE, ROM_BASE};
  localparam logic [N_SLV_DEF-1:0][31:0] DEF_SLV_TOP  = {AVL_TOP,  CLINT_TOP,  UART_TOP,  ROM_TOP};

  // Cycles a slave may take before the access is failed back to the master
  localparam int DEF_TIMEOUT = 1023;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_ERR  = 2'd3
  } xbar_state_e;

  // True when addr falls in the half-open window [base, top)
  function automatic logic in_window(input logic [31:0] addr,
                                     input logic [31:0] base,
                                     input logic [31:0] top);
    return (addr >= base) && (addr < top);
  endfunction

endpackage

// File: rtl/mem_xbar_rr_arbiter.sv
// rtl/mem_xbar_rr_arbiter.sv - combinational round-robin picker starting at a rotating pointer
module mem_xbar_rr_arbiter
  import mem_xbar_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o
);

  int  cand;
  logic found;

  // Walk the requesters from ptr_i upward with wrap; the first one found wins
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    cand    = 0;
    for (int i = 0; i < N; i++) begin
      cand = int'(ptr_i) + i;
      if (cand >= N) cand = cand - N;
      if (!found && req_i[cand]) begin
        found         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_xbar.sv
// rtl/mem_xbar.sv - registered N-master to N-slave memory crossbar with decode errors and timeout
module mem_xbar
  import mem_xbar_pkg::*;
#(
  parameter int                         N_MASTER = 2,
  parameter int                         N_SLAVE  = 4,
  parameter logic [N_SLAVE-1:0][31:0]   SLV_BASE = DEF_SLV_BASE,
  parameter logic [N_SLAVE-1:0][31:0]   SLV_TOP  = DEF_SLV_TOP,
  parameter int                         TIMEOUT  = DEF_TIMEOUT
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [N_MASTER-1:0]          m_valid,
  input  logic [N_MASTER-1:0]          m_instr,
  input  logic [N_MASTER-1:0][31:0]    m_addr,
  input  logic [N_MASTER-1:0][31:0]    m_wdata,
  input  logic [N_MASTER-1:0][3:0]     m_wstrb,
  output logic [N_MASTER-1:0][31:0]    m_rdata,
  output logic [N_MASTER-1:0]          m_ready,
  output logic [N_MASTER-1:0]          m_error,
  output logic [N_SLAVE-1:0]           s_valid,
  output logic [N_SLAVE-1:0]           s_instr,
  output logic [N_SLAVE-1:0][31:0]     s_addr,
  output logic [N_SLAVE-1:0][31:0]     s_wdata,
  output logic [N_SLAVE-1:0][3:0]      s_wstrb,
  input  logic [N_SLAVE-1:0][31:0]     s_rdata,
  input  logic [N_SLAVE-1:0]           s_ready
);

  localparam int MW = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
  localparam int SW = (N_SLAVE > 1) ? $clog2(N_SLAVE) : 1;
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  // Counter value seen in the last cycle the slave is allowed to answer in
  localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic          TO_ON    = (TIMEOUT > 0);

  xbar_state_e     state_q;
  logic [MW-1:0]   ptr_q;
  logic [MW-1:0]   ptr_d;
  logic [CW-1:0]   cnt_q;
  logic [MW-1:0]   gnt_q;
  logic [SW-1:0]   slv_q;
  logic            instr_q;
  logic [31:0]     addr_q;
  logic [31:0]     wdata_q;
  logic [3:0]      wstrb_q;

  logic [N_MASTER-1:0] arb_grant;
  logic [MW-1:0]       arb_idx;
  logic                arb_any;
  logic [31:0]         req_addr;
  logic                dec_hit;
  logic [SW-1:0]       dec_idx;

  logic busy;
  logic hit_rdy;
  logic to_fire;
  logic rsp_err;
  logic rsp_any;

  mem_xbar_rr_arbiter #(
    .N  (N_MASTER),
    .IW (MW)
  ) u_arb (
    .req_i   (m_valid),
    .ptr_i   (ptr_q),
    .grant_o (arb_grant),
    .idx_o   (arb_idx)
  );

  assign arb_any = |arb_grant;

  // Decode the granted address; scanning downward lets the lowest matching slave win overlaps
  always_comb begin
    req_addr = m_addr[arb_idx];
    dec_hit  = 1'b0;
    dec_idx  = '0;
    for (int k = N_SLAVE - 1; k >= 0; k--) begin
      if (in_window(req_addr, SLV_BASE[k], SLV_TOP[k])) begin
        dec_hit = 1'b1;
        dec_idx = SW'(k);
      end
    end
  end

  // Only the selected slave's ready counts, and only while a request is outstanding
  assign busy    = (state_q == ST_REQ) || (state_q == ST_WAIT);
  assign hit_rdy = busy && s_ready[slv_q];
  assign to_fire = TO_ON && busy && !s_ready[slv_q] && (cnt_q == CNT_LAST);
  assign rsp_err = (state_q == ST_ERR) || to_fire;
  assign rsp_any = hit_rdy || rsp_err;

  // Rotate the pointer past whichever master was just answered
  always_comb begin
    ptr_d = (gnt_q == MW'(N_MASTER - 1)) ? '0 : gnt_q + 1'b1;
  end

  // Steer the latched request to its slave and the response back to the granted master
  always_comb begin
    m_ready = '0;
    m_error = '0;
    m_rdata = '0;
    s_valid = '0;
    s_instr = '0;
    s_addr  = '0;
    s_wdata = '0;
    s_wstrb = '0;
    m_ready[gnt_q] = rsp_any;
    m_error[gnt_q] = rsp_err;
    if (hit_rdy) begin
      m_rdata[gnt_q] = s_rdata[slv_q];
    end
    if (busy) begin
      s_valid[slv_q] = (state_q == ST_REQ);
      s_instr[slv_q] = instr_q;
      s_addr[slv_q]  = addr_q;
      s_wdata[slv_q] = wdata_q;
      s_wstrb[slv_q] = wstrb_q;
    end
  end

  // Transaction FSM: arbitrate and decode in IDLE, hold one access until ready, error or timeout
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt_q   <= '0;
      slv_q   <= '0;
      instr_q <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (arb_any) begin
            gnt_q <= arb_idx;
            cnt_q <= '0;
            if (dec_hit) begin
              slv_q   <= dec_idx;
              instr_q <= m_instr[arb_idx];
              addr_q  <= req_addr - SLV_BASE[dec_idx];
              wdata_q <= m_wdata[arb_idx];
              wstrb_q <= m_wstrb[arb_idx];
              state_q <= ST_REQ;
            end else begin
              state_q <= ST_ERR;
            end
          end
        end
        ST_REQ, ST_WAIT: begin
          if (rsp_any) begin
            state_q <= ST_IDLE;
            ptr_q   <= ptr_d;
          end else begin
            state_q <= ST_WAIT;
            cnt_q   <= cnt_q + 1'b1;
          end
        end
        ST_ERR: begin
          state_q <= ST_IDLE;
          ptr_q   <= ptr_d;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_xbar.sv
// tb/tb_mem_xbar.sv - directed table-driven bench for mem_xbar
module tb_mem_xbar;
  import mem_xbar_pkg::*;

  localparam int NM = 2;
  localparam int NS = 4;
  localparam int TO = 8;

  // ROM and UART overlap on [0x1000, 0x1004); UART base + 4 lies only in UART
  localparam logic [NS-1:0][31:0] TB_BASE = {32'h8000_0000, 32'h0200_0000, 32'h0000_1000, 32'h0000_0000};
  localparam logic [NS-1:0][31:0] TB_TOP  = {32'h9000_0000, 32'h0201_0000, 32'h0000_2000, 32'h0000_1004};
  localparam logic [NS-1:0][31:0] RD_VAL  = {32'h4444_4444, 32'h3333_3333, 32'hDEAD_BEEF, 32'h1111_0000};

  logic                     clock;
  logic                     reset;
  logic [NM-1:0]            m_valid;
  logic [NM-1:0]            m_instr;
  logic [NM-1:0][31:0]      m_addr;
  logic [NM-1:0][31:0]      m_wdata;
  logic [NM-1:0][3:0]       m_wstrb;
  logic [NM-1:0][31:0]      m_rdata;
  logic [NM-1:0]            m_ready;
  logic [NM-1:0]            m_error;
  logic [NS-1:0]            s_valid;
  logic [NS-1:0]            s_instr;
  logic [NS-1:0][31:0]      s_addr;
  logic [NS-1:0][31:0]      s_wdata;
  logic [NS-1:0][3:0]       s_wstrb;
  logic [NS-1:0][31:0]      s_rdata;
  logic [NS-1:0]            s_ready;

  mem_xbar #(
    .N_MASTER (NM),
    .N_SLAVE  (NS),
    .SLV_BASE (TB_BASE),
    .SLV_TOP  (TB_TOP),
    .TIMEOUT  (TO)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .m_valid (m_valid),
    .m_instr (m_instr),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_wstrb (m_wstrb),
    .m_rdata (m_rdata),
    .m_ready (m_ready),
    .m_error (m_error),
    .s_valid (s_valid),
    .s_instr (s_instr),
    .s_addr  (s_addr),
    .s_wdata (s_wdata),
    .s_wstrb (s_wstrb),
    .s_rdata (s_rdata),
    .s_ready (s_ready)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  assign s_rdata = RD_VAL;

  // Slave model: ready L cycles after s_valid (L=0 same cycle, L<0 never)
  int            lat [NS];
  int            cd  [NS];
  logic [NS-1:0] force_rdy;

  always @(posedge clock or posedge reset) begin
    for (int k = 0; k < NS; k++) begin
      if (reset) cd[k] <= 0;
      else if (cd[k] > 0) cd[k] <= cd[k] - 1;
      else if (s_valid[k] && lat[k] > 0) cd[k] <= lat[k];
    end
  end

  always_comb begin
    s_ready = '0;
    for (int k = 0; k < NS; k++)
      s_ready[k] = force_rdy[k] | (s_valid[k] && lat[k] == 0) | (cd[k] == 1);
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    int          m;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        instr;
    int          lat;
    int          exp_slv;
    logic [31:0] exp_saddr;
    int          exp_cyc;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs [8];

  task automatic do_vec(input vec_t v, input string tag);
    int          sv_slv = -1;
    int          sv_cyc = -1;
    int          sv_cnt = 0;
    int          rdy_cyc = -1;
    int          extra = 0;
    logic [31:0] sv_addr = 0;
    logic [31:0] sv_wdata = 0;
    logic [3:0]  sv_wstrb = 0;
    logic        sv_instr = 0;
    logic [31:0] rd = 0;
    logic        er = 0;
    logic        others = 0;
    if (v.exp_slv >= 0) lat[v.exp_slv] = v.lat;
    @(posedge clock); #1;
    m_valid[v.m] = 1'b1;
    m_addr[v.m]  = v.addr;
    m_wdata[v.m] = v.wdata;
    m_wstrb[v.m] = v.wstrb;
    m_instr[v.m] = v.instr;
    for (int c = 0; c < 40 && rdy_cyc < 0; c++) begin
      @(negedge clock);
      for (int k = 0; k < NS; k++) begin
        if (s_valid[k]) begin
          sv_cnt++;
          sv_slv   = k;
          sv_cyc   = c;
          sv_addr  = s_addr[k];
          sv_wdata = s_wdata[k];
          sv_wstrb = s_wstrb[k];
          sv_instr = s_instr[k];
        end
      end
      if (m_ready != '0) begin
        rdy_cyc = c;
        rd      = m_rdata[v.m];
        er      = m_error[v.m];
        others  = (m_ready != (NM'(1) << v.m)) || (m_rdata[1 - v.m] != 0);
      end
      @(posedge clock); #1;
    end
    m_valid[v.m] = 1'b0;
    m_addr[v.m]  = '0;
    m_wdata[v.m] = '0;
    m_wstrb[v.m] = '0;
    m_instr[v.m] = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (m_ready != '0) extra++;
      @(posedge clock); #1;
    end
    chk($sformatf("%s_rdy_cyc", tag), rdy_cyc, v.exp_cyc);
    chk($sformatf("%s_rdata", tag), rd, v.exp_rdata);
    chk($sformatf("%s_error", tag), 32'(er), 32'(v.exp_err));
    chk($sformatf("%s_other_master", tag), 32'(others), 0);
    chk($sformatf("%s_extra_ready", tag), extra, 0);
    chk($sformatf("%s_s_valid_count", tag), sv_cnt, (v.exp_slv >= 0) ? 1 : 0);
    if (v.exp_slv >= 0) begin
      chk($sformatf("%s_slave", tag), sv_slv, v.exp_slv);
      chk($sformatf("%s_s_valid_cyc", tag), sv_cyc, 1);
      chk($sformatf("%s_s_addr", tag), sv_addr, v.exp_saddr);
      chk($sformatf("%s_s_wdata", tag), sv_wdata, v.wdata);
      chk($sformatf("%s_s_wstrb", tag), 32'(sv_wstrb), 32'(v.wstrb));
      chk($sformatf("%s_s_instr", tag), 32'(sv_instr), 32'(v.instr));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_time_limit actual=expired required=finished");
    $fatal(1, "time limit");
  end

  initial begin
    int          rdy_cyc;
    int          extra;
    int          n_got;
    logic [31:0] rd;
    logic        er;
    int          g_idx [4];
    int          g_cyc [4];
    logic [31:0] g_rd  [4];

    m_valid   = '0;
    m_instr   = '0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    force_rdy = '0;
    for (int k = 0; k < NS; k++) lat[k] = 1;

    //            m  addr           wdata          wstrb instr lat slv saddr          cyc rdata          err
    vecs[0] = '{0, 32'h0000_1004, 32'h0,         4'h0, 1'b0, 2,  1, 32'h0000_0004, 3, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{1, 32'hFFFF_0000, 32'h1234_5678, 4'hF, 1'b0, 0, -1, 32'h0,         1, 32'h0,         1'b1};
    vecs[2] = '{0, 32'h0000_1000, 32'h0,         4'h0, 1'b0, 0,  0, 32'h0000_1000, 1, 32'h1111_0000, 1'b0};
    vecs[3] = '{1, 32'h8000_0010, 32'hCAFE_F00D, 4'h3, 1'b0, 1,  3, 32'h0000_0010, 2, 32'h4444_4444, 1'b0};
    vecs[4] = '{0, 32'h0000_0FFC, 32'h0,         4'h0, 1'b1, 3,  0, 32'h0000_0FFC, 4, 32'h1111_0000, 1'b0};
    vecs[5] = '{1, 32'h0000_2000, 32'h0,         4'h0, 1'b0, 0, -1, 32'h0,         1, 32'h0,         1'b1};
    vecs[6] = '{1, 32'h0200_0000, 32'h0000_00A5, 4'h1, 1'b0, 0,  2, 32'h0000_0000, 1, 32'h3333_3333, 1'b0};
    vecs[7] = '{0, 32'h8FFF_FFFC, 32'h0,         4'h0, 1'b0, 2,  3, 32'h0FFF_FFFC, 3, 32'h4444_4444, 1'b0};

    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_m_ready", 32'(m_ready), 0);
    chk("rst_m_error", 32'(m_error), 0);
    chk("rst_m_rdata", 32'(|m_rdata), 0);
    chk("rst_s_valid", 32'(s_valid), 0);
    chk("rst_s_fields", 32'(|{s_addr, s_wdata, s_wstrb, s_instr}), 0);
    reset = 1'b0;

    for (int i = 0; i < 8; i++) do_vec(vecs[i], $sformatf("vec%0d", i));

    // Timeout: CLINT never answers, then answers late after the error
    lat[SLV_CLINT] = -1;
    rdy_cyc = -1;
    rd = 32'hFFFF_FFFF;
    er = 1'b0;
    @(posedge clock); #1;
    m_valid[0] = 1'b1;
    m_addr[0]  = 32'h0200_0004;
    for (int c = 0; c < 30 && rdy_cyc < 0; c++) begin
      @(negedge clock);
      if (m_ready[0]) begin
        rdy_cyc = c;
        er      = m_error[0];
        rd      = m_rdata[0];
      end
      @(posedge clock); #1;
    end
    m_valid[0] = 1'b0;
    m_addr[0]  = '0;
    chk("to_rdy_cyc", rdy_cyc, TO);
    chk("to_error", 32'(er), 1);
    chk("to_rdata", rd, 0);
    extra = 0;
    for (int c = rdy_cyc + 1; c < rdy_cyc + 8; c++) begin
      force_rdy[SLV_CLINT] = (c == rdy_cyc + 3);
      @(negedge clock);
      if (m_ready != '0) extra++;
      @(posedge clock); #1;
    end
    force_rdy = '0;
    chk("to_late_ready_ignored", extra, 0);
    lat[SLV_CLINT] = 0;

    // Master 0 completes so the pointer moves to master 1 before the reset test
    do_vec('{0, 32'h0000_0000, 32'h0, 4'h0, 1'b0, 0, 0, 32'h0, 1, 32'h1111_0000, 1'b0}, "pre_rst");

    // Reset while master 1 waits on UART
    lat[SLV_UART] = 6;
    @(posedge clock); #1;
    m_valid[1] = 1'b1;
    m_addr[1]  = 32'h0000_1008;
    repeat (3) @(posedge clock);
    #3;
    chk("wait_s_addr", s_addr[SLV_UART], 32'h0000_0008);
    reset = 1'b1;
    #1;
    chk("arst_m_ready", 32'(m_ready), 0);
    chk("arst_m_rdata", 32'(|m_rdata), 0);
    chk("arst_s_valid", 32'(s_valid), 0);
    chk("arst_s_fields", 32'(|{s_addr, s_wdata, s_wstrb, s_instr}), 0);
    m_valid[1] = 1'b0;
    m_addr[1]  = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Both masters hammer ROM; pointer restarts at 0 after reset
    lat[SLV_ROM] = 1;
    n_got = 0;
    for (int i = 0; i < 4; i++) begin
      g_idx[i] = -1;
      g_cyc[i] = -1;
      g_rd[i]  = '0;
    end
    @(posedge clock); #1;
    m_valid   = 2'b11;
    m_addr[0] = 32'h0000_0100;
    m_addr[1] = 32'h0000_0200;
    for (int c = 0; c < 40 && n_got < 4; c++) begin
      @(negedge clock);
      if (m_ready != '0) begin
        g_idx[n_got] = (m_ready == 2'b01) ? 0 : (m_ready == 2'b10) ? 1 : 9;
        g_cyc[n_got] = c;
        g_rd[n_got]  = (m_ready == 2'b10) ? m_rdata[1] : m_rdata[0];
        n_got++;
      end
      @(posedge clock); #1;
    end
    m_valid = '0;
    m_addr  = '0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rr%0d_grant", i), g_idx[i], i % 2);
      chk($sformatf("rr%0d_cyc", i), g_cyc[i], 2 + 3 * i);
      chk($sformatf("rr%0d_rdata", i), g_rd[i], 32'h1111_0000);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
